// File: rtl/tmds_pkg.sv
// TMDS symbol definitions shared by the transmit encoder and receive decoder:
// control tokens, alignment state and the 10b -> 8b/2b decode.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctrl;
    logic [7:0] data;
  } tmds_sym_t;

  function automatic logic tmds_is_token(input logic [9:0] q);
    return (q == TMDS_CTRL_00) || (q == TMDS_CTRL_01) ||
           (q == TMDS_CTRL_10) || (q == TMDS_CTRL_11);
  endfunction

  // q[9] undoes the optional inversion, q[8] selects XOR vs XNOR chaining.
  function automatic tmds_sym_t tmds_decode(input logic [9:0] q);
    tmds_sym_t  s;
    logic [7:0] d;
    s = '0;
    d = q[9] ? ~q[7:0] : q[7:0];
    case (q)
      TMDS_CTRL_00: begin s.is_token = 1'b1; s.ctrl = 2'b00; end
      TMDS_CTRL_01: begin s.is_token = 1'b1; s.ctrl = 2'b01; end
      TMDS_CTRL_10: begin s.is_token = 1'b1; s.ctrl = 2'b10; end
      TMDS_CTRL_11: begin s.is_token = 1'b1; s.ctrl = 2'b11; end
      default: begin
        s.data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
          s.data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_rx_channel_if.sv
// Bus between the deserializer/consumer and one TMDS receive channel.
// de is the only qualifier: data is meaningful when de=1; there is no
// backpressure, so the consumer must take every symbol on the cycle it appears.
interface tmds_rx_channel_if;
  import tmds_pkg::*;

  logic [9:0]   raw_word;
  logic [7:0]   data;
  logic [1:0]   ctrl;
  logic         de;
  logic         locked;
  logic [3:0]   slip;
  align_state_t state;

  modport master (output raw_word, input data, ctrl, de, locked, slip, state);
  modport slave  (input raw_word, output data, ctrl, de, locked, slip, state);
endinterface

// File: rtl/tmds_word_aligner.sv
// Finds 10-bit symbol alignment by slipping one bit at a time until a run of
// control tokens is seen; drops lock when tokens stop arriving.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 16,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [9:0]   raw_word,
  output logic [9:0]   sym_q,
  output logic         locked,
  output logic [3:0]   slip,
  output align_state_t state
);

  localparam int WD_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int WD_W   = $clog2(WD_MAX) + 1;

  localparam logic [RUN_W-1:0] RUN_SAT     = RUN_W'(LOCK_TOKENS);
  localparam logic [WD_W-1:0]  SEARCH_LAST = WD_W'(SEARCH_WINDOW - 1);
  localparam logic [WD_W-1:0]  LOSS_LAST   = WD_W'(LOSS_WINDOW - 1);

  align_state_t     state_q, state_d;
  logic [9:0]       prev_q;
  logic [19:0]      win;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [3:0]       slip_q, slip_d;
  logic             discard_q;
  logic             slip_step;
  logic             tok;

  assign win = {raw_word, prev_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      sym_q     <= '0;
      run_q     <= '0;
      wd_q      <= '0;
      slip_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= raw_word;
      sym_q     <= win[slip_q +: 10];
      run_q     <= run_d;
      wd_q      <= wd_d;
      slip_q    <= slip_d;
      discard_q <= slip_step;
    end
  end

  // A symbol captured with the pre-slip offset is neither a token nor a break.
  assign tok     = tmds_is_token(sym_q) && !discard_q;
  assign run_inc = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    wd_d      = wd_q;
    slip_step = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (tok && (run_inc == RUN_SAT)) begin
          state_d = LOCKED;
          run_d   = run_inc;
          wd_d    = '0;
        end else if (tok) begin
          run_d = run_inc;
          wd_d  = '0;
        end else if (wd_q == SEARCH_LAST) begin
          slip_step = 1'b1;
          run_d     = '0;
          wd_d      = '0;
        end else begin
          if (!discard_q) run_d = '0;
          wd_d = wd_q + 1'b1;
        end
      end
      LOCKED: begin
        if (tok) begin
          wd_d = '0;
        end else if (wd_q == LOSS_LAST) begin
          state_d   = SEARCH;
          slip_step = 1'b1;
          run_d     = '0;
          wd_d      = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    slip_d = slip_q;
    if (slip_step) slip_d = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
  end

  assign locked = (state_q == LOCKED);
  assign slip   = slip_q;
  assign state  = state_q;

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: word alignment followed by a registered decode of
// each symbol into pixel data or control bits, gated until alignment locks.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 16,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOSS_WINDOW   = 4096
) (
  input logic               clk_pix,
  input logic               rst_n_pix,
  tmds_rx_channel_if.slave  bus
);

  logic [9:0]   sym_q;
  logic         locked;
  logic [3:0]   slip;
  align_state_t state;
  tmds_sym_t    dec;
  logic [7:0]   data_q;
  logic [1:0]   ctrl_q;
  logic         de_q;

  tmds_word_aligner #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .LOSS_WINDOW  (LOSS_WINDOW)
  ) u_aligner (
    .clk     (clk_pix),
    .rst_n   (rst_n_pix),
    .raw_word(bus.raw_word),
    .sym_q   (sym_q),
    .locked  (locked),
    .slip    (slip),
    .state   (state)
  );

  assign dec = tmds_decode(sym_q);

  // ctrl deliberately holds across data symbols so blanking state persists.
  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else if (!locked) begin
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else if (dec.is_token) begin
      data_q <= '0;
      ctrl_q <= dec.ctrl;
      de_q   <= 1'b0;
    end else begin
      data_q <= dec.data;
      de_q   <= 1'b1;
    end
  end

  assign bus.data   = data_q;
  assign bus.ctrl   = ctrl_q;
  assign bus.de     = de_q;
  assign bus.locked = locked;
  assign bus.slip   = slip;
  assign bus.state  = state;

endmodule

// File: doc/tmds_rx_channel.md
# tmds_rx_channel

Single-channel TMDS receive decoder for the DVI/HDMI path: takes unaligned 10-bit parallel words from a 10:1 deserializer in the pixel clock domain, finds symbol alignment by bit-slipping until control tokens lock, and decodes each symbol to 8-bit pixel data or 2-bit control. It performs the inverse of the TMDS encoding done by the `hdmi` output block. Three instances, one per colour channel, form a loopback and capture path for checking `vdp` video output.

## Interface
- `LOCK_TOKENS`, 16: number of consecutive control tokens needed to declare lock.
- `SEARCH_WINDOW`, 4096: cycles without a token before advancing slip while searching. Must exceed one video line.
- `LOSS_WINDOW`, 4096: cycles without a token before dropping lock.
- `clk_pix` in 1: pixel clock; the only clock.
- `rst_n_pix` in 1: reset, asynchronous, active-low.
- `raw_word` in 10: deserialized bits, LSB is earliest on the wire, not aligned to symbols.
- `data` out 8: decoded pixel byte.
- `ctrl` out 2: decoded control bits {c1,c0}.
- `de` out 1: current symbol is a data symbol.
- `locked` out 1: alignment locked.
- `slip` out 4: current bit offset, range 0..9.

## Operation
- **Window:** `prev_q <= raw_word` each cycle. The aligned symbol is `{raw_word, prev_q}[slip +: 10]`, registered into `sym_q` (stage 1).
- **Token test** on `sym_q`:
  - 0x354 → 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
- **Decode** (stage 2, registered):
  - Token: `de`=0, `ctrl`=token value, `data`=0.
  - Otherwise `de`=1 and `ctrl` holds its last value. Let d = q[9] ? ~q[7:0] : q[7:0]. Then `data[0]`=d[0], and for i=1..7, `data[i]` = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- **Gating:** while `locked`=0, stage 2 forces `de`=0, `data`=0, `ctrl`=0.
- **FSM state SEARCH:**
  - `run` counts consecutive tokens in `sym_q`. A non-token clears it.
  - `wd` counts cycles since the last token.
  - When `run` reaches LOCK_TOKENS, go to LOCKED and set `locked`=1.
  - Otherwise, when `wd` reaches SEARCH_WINDOW−1, increment `slip` modulo 10 (9→0) and clear `run` and `wd`.
  - Lock takes priority over timeout in the same cycle.
- **FSM state LOCKED:**
  - Any token clears `wd`.
  - When `wd` reaches LOSS_WINDOW−1, go to SEARCH, clear `locked`, increment `slip` modulo 10, and clear `run` and `wd`.
- **After any slip change:** the next `sym_q` (built with the old slip) is discarded by a one-cycle flag. It does not count as a token or as a break.
- **Counters:** `run` saturates at LOCK_TOKENS. Width is $clog2 of the respective parameter plus 1.

## Timing
- **Reset:** on `rst_n_pix` low, immediately clear `data`, `ctrl`, `de`, `locked`, `slip`, `prev_q`, `sym_q`, `run`, `wd` and the discard flag, and enter SEARCH. This applies mid-stream too.
- **Latency:** a symbol whose bit 0 sits at `raw_word[slip]` in the word sampled at edge N appears on the outputs after edge N+2.
- **Lock timing:** `locked` rises on the edge where stage 1 evaluates the LOCK_TOKENS-th consecutive token. The decode of that token is still gated.
- **Slip timing:** `slip` changes at the timeout edge and takes effect on the following stage-1 capture.

## Structure
- **Package `tmds_pkg`:**
  - `TMDS_CTRL_00`..`TMDS_CTRL_11` token constants.
  - `align_state_t` enum {SEARCH, LOCKED}.
  - `tmds_decode` function.
  - Shared with the transmit-side encoder.
- **Sub-module `tmds_word_aligner`:** window, slip, FSM, `run`/`wd` counters and discard flag. It outputs `sym_q`, `locked` and `slip`. Decode stays in `tmds_rx_channel`.

## Test plan
Benches use SEARCH_WINDOW=LOSS_WINDOW=64 and LOCK_TOKENS=16.

1. **Aligned lock and decode:** feed 16×0x354, then 0x100, then 0x200 at bit offset 0.
   - `locked`=1 while slip stays 0.
   - Then `de`=1, `data`=0x00, then `data`=0xFF, two cycles after each word.
   - `ctrl`=00 holds.
2. **Misaligned lock:** feed a continuous 0x354 stream delayed 3 bits.
   - Slip steps 0→1→2→3, one step per 64 token-free cycles. Other rotations are never tokens.
   - `locked` rises at slip=3 within 3·64+16+4 cycles.
3. **Run break:** feed 15 tokens, one 0x100, then 15 tokens → `locked` stays 0.
   - One more token → `locked`=1.
4. **Loss of lock:** once locked, feed only 0x100.
   - `locked` falls after 64 cycles.
   - `slip` increments by 1.
   - `de`/`data` forced 0 from the next stage-2 edge.
5. **Slip wrap:** feed all-zero words for 10×64 cycles → slip walks 0..9 and then wraps to 0.
6. **Async reset:** pulse `rst_n_pix` low while locked and mid-data → all outputs read 0 before the next clock edge, and relock takes 16 tokens.
